vm_payout: RTL and testbench

VM_PAYOUT -- requirements
Module: vm_payout

---
 rtl/vm_payout.sv | 124 ++++++++++++
 tb/tb_vm_payout.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vm_payout.sv
// Purpose: vend payout sequencer; pulses the product drop, then ejects and confirms each owed coin.
// Latency: item_drop rises the cycle after vend; done pulses one cycle after the last coin is sensed.
// Backpressure: none; a vend that arrives while busy is dropped and flagged with a one-cycle overrun.
module vm_payout #(
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vend,
  input  logic [2:0] change,
  input  logic       coin_sensed,
  output logic       item_drop,
  output logic       coin_eject,
  output logic [2:0] pending,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DROP  = 3'd1,
    S_EJECT = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  localparam logic [3:0] PULSE_LAST = 4'(PULSE_LEN - 1);
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [3:0] pcnt_q, pcnt_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic [2:0] pending_q, pending_d;
  logic       item_drop_q, coin_eject_q, busy_q, done_q, overrun_q, fault_q;

  // Next-state, pulse/timeout counters and owed-coin count.
  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    tcnt_d    = tcnt_q;
    pending_d = pending_q;
    case (state_q)
      S_IDLE: begin
        if (vend) begin
          pending_d = change;
          pcnt_d    = 4'd0;
          state_d   = S_DROP;
        end
      end
      S_DROP: begin
        if (pcnt_q == PULSE_LAST) begin
          pcnt_d  = 4'd0;
          state_d = (pending_q == 3'd0) ? S_DONE : S_EJECT;
        end else begin
          pcnt_d = pcnt_q + 4'd1;
        end
      end
      S_EJECT: begin
        if (pcnt_q == PULSE_LAST) begin
          pcnt_d  = 4'd0;
          tcnt_d  = 8'd0;
          state_d = S_WAIT;
        end else begin
          pcnt_d = pcnt_q + 4'd1;
        end
      end
      S_WAIT: begin
        // A sense in the last timeout cycle still counts as a paid coin.
        if (coin_sensed) begin
          pending_d = (pending_q == 3'd0) ? 3'd0 : pending_q - 3'd1;
          pcnt_d    = 4'd0;
          state_d   = (pending_q <= 3'd1) ? S_DONE : S_EJECT;
        end else if (tcnt_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered outputs; reset abandons any vend in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pcnt_q       <= 4'd0;
      tcnt_q       <= 8'd0;
      pending_q    <= 3'd0;
      item_drop_q  <= 1'b0;
      coin_eject_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      tcnt_q       <= tcnt_d;
      pending_q    <= pending_d;
      item_drop_q  <= (state_d == S_DROP);
      coin_eject_q <= (state_d == S_EJECT);
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_DONE);
      overrun_q    <= vend && (state_q != S_IDLE);
      fault_q      <= (state_d == S_FAULT);
    end
  end

  assign item_drop  = item_drop_q;
  assign coin_eject = coin_eject_q;
  assign pending    = pending_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overrun    = overrun_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_vm_payout.sv
// Randomized bench for vm_payout: a transaction-level model expands each vend into its
// expected per-cycle output trace, the driver pushes it into a scoreboard queue, and an
// independent monitor pops and compares one entry per clock.
module tb_vm_payout;
  localparam int P = 4;
  localparam int T = 16;
  localparam int C_FREE = 0;
  localparam int C_ONE  = 1;
  localparam int C_ZERO = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vend = 1'b0;
  logic [2:0] change = 3'd0;
  logic       coin_sensed = 1'b0;
  logic       item_drop, coin_eject, busy, done, overrun, fault;
  logic [2:0] pending;

  always #5 clk = ~clk;

  vm_payout #(.PULSE_LEN(P), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .vend(vend), .change(change), .coin_sensed(coin_sensed),
    .item_drop(item_drop), .coin_eject(coin_eject), .pending(pending),
    .busy(busy), .done(done), .overrun(overrun), .fault(fault)
  );

  typedef struct packed {
    logic       item_drop;
    logic       coin_eject;
    logic [2:0] pending;
    logic       busy;
    logic       done;
    logic       overrun;
    logic       fault;
  } obs_t;

  obs_t sb_q[$];
  obs_t plan_o[$];
  int   plan_c[$];
  int   next_c;
  int   checks = 0;
  int   fails  = 0;

  function automatic obs_t mk(bit d, bit e, int p, bit b, bit dn, bit f);
    obs_t o;
    o.item_drop  = d;
    o.coin_eject = e;
    o.pending    = 3'(p);
    o.busy       = b;
    o.done       = dn;
    o.overrun    = 1'b0;
    o.fault      = f;
    return o;
  endfunction

  // Each planned cycle carries the constraint on the coin_sensed input that produces it.
  task automatic push(input obs_t o, input int after);
    plan_o.push_back(o);
    plan_c.push_back(next_c);
    next_c = after;
  endtask

  task automatic step(input logic r, input logic v, input logic [2:0] ch, input logic s, input obs_t e);
    @(negedge clk);
    rst = r; vend = v; change = ch; coin_sensed = s;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 0));
  endtask

  // c coins owed; w_fix>0 fixes the WAIT length; fault_coin times out that coin;
  // rst_at>=0 replaces that cycle with a reset; ovr_pct is the chance of a stray vend per busy cycle.
  task automatic plan_vend(input int c, input int w_fix, input int fault_coin, input int rst_at, input int ovr_pct);
    int   p, w, n, lim, ra;
    bit   faulted;
    bit   s;
    obs_t o;
    plan_o.delete();
    plan_c.delete();
    next_c  = C_FREE;
    faulted = 1'b0;
    for (int i = 0; i < P; i++) push(mk(1, 0, c, 1, 0, 0), C_FREE);
    p = c;
    for (int k = 0; k < c && !faulted; k++) begin
      for (int i = 0; i < P; i++) push(mk(0, 1, p, 1, 0, 0), C_FREE);
      if (k == fault_coin) begin
        for (int i = 0; i < T; i++) push(mk(0, 0, p, 1, 0, 0), C_ZERO);
        for (int i = 0; i < 6; i++) push(mk(0, 0, p, 1, 0, 1), C_FREE);
        faulted = 1'b1;
      end else begin
        w = (w_fix > 0) ? w_fix : $urandom_range(1, T);
        for (int i = 0; i < w - 1; i++) push(mk(0, 0, p, 1, 0, 0), C_ZERO);
        push(mk(0, 0, p, 1, 0, 0), C_ONE);
        p = p - 1;
      end
    end
    if (!faulted) begin
      push(mk(0, 0, 0, 1, 1, 0), C_FREE);
      push(mk(0, 0, 0, 0, 0, 0), C_FREE);
    end
    n  = plan_o.size();
    ra = rst_at;
    if (faulted && (ra < 0 || ra > n)) ra = n;
    if (ra > n) ra = n;
    lim = (ra >= 0) ? ra : n - 1;
    for (int t = 0; t <= lim; t++) begin
      if (t == ra) begin
        step(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 0, 0));
      end else begin
        o = plan_o[t];
        case (plan_c[t])
          C_ONE:   s = 1'b1;
          C_ZERO:  s = 1'b0;
          default: s = 1'($urandom_range(0, 1));
        endcase
        if (t == 0) begin
          step(1'b0, 1'b1, 3'(c), s, o);
        end else if ($urandom_range(0, 99) < ovr_pct) begin
          o.overrun = 1'b1;
          step(1'b0, 1'b1, 3'($urandom_range(0, 7)), s, o);
        end else begin
          step(1'b0, 1'b0, 3'($urandom_range(0, 7)), s, o);
        end
      end
    end
  endtask

  // Monitor: one comparison per clock whenever the scoreboard holds an expectation.
  initial begin
    obs_t e, g;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        g = {item_drop, coin_eject, pending, busy, done, overrun, fault};
        checks++;
        if (g !== e) begin
          fails++;
          $display("FAIL outputs @%0t: got drop=%b ej=%b pend=%0d busy=%b done=%b ovr=%b flt=%b; want drop=%b ej=%b pend=%0d busy=%b done=%b ovr=%b flt=%b",
                   $time, g.item_drop, g.coin_eject, g.pending, g.busy, g.done, g.overrun, g.fault,
                   e.item_drop, e.coin_eject, e.pending, e.busy, e.done, e.overrun, e.fault);
        end
        if (item_drop && coin_eject) begin
          fails++;
          $display("FAIL exclusive_actuators @%0t: both item_drop and coin_eject high", $time);
        end
      end
    end
  end

  // Stimulus: reset with a discarded vend, directed scenarios, then random traffic.
  initial begin
    int c, mode, fc, ra;
    step(1'b1, 1'b1, 3'd5, 1'b1, mk(0, 0, 0, 0, 0, 0));
    step(1'b1, 1'b1, 3'd3, 1'b0, mk(0, 0, 0, 0, 0, 0));
    idle(3);
    plan_vend(0, 0, -1, -1, 0);
    idle(2);
    plan_vend(3, 2, -1, -1, 0);
    idle(2);
    plan_vend(2, 0, 0, -1, 0);
    idle(2);
    plan_vend(1, T, -1, -1, 0);
    idle(2);
    plan_vend(1, 0, -1, -1, 100);
    idle(2);
    plan_vend(7, 0, -1, P + 2, 0);
    plan_vend(1, 0, -1, -1, 0);
    idle(2);
    for (int it = 0; it < 150; it++) begin
      c    = $urandom_range(0, 7);
      mode = $urandom_range(0, 9);
      fc   = -1;
      ra   = -1;
      if (mode >= 6 && mode <= 7 && c > 0) fc = $urandom_range(0, c - 1);
      if (mode >= 8) ra = $urandom_range(1, P + c * (P + 4) + 2);
      plan_vend(c, 0, fc, ra, 10);
      idle($urandom_range(0, 3));
    end
    repeat (2) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
